// File: rtl/bno085_spi_arbiter.sv
// -----------------------------------------------------------------------------
// bno085_spi_arbiter
//
// Shares a single spi_master between two bno085_controller instances
// (sensor 1 = right hand, sensor 2 = left hand). The grant is held for a whole
// CS-framed transaction. Each sensor's chip select is derived from its grant,
// so the shared sclk/mosi lines only carry one transaction at a time.
//
// Arbitration is round-robin on ties. A hold watchdog forcibly releases a
// requester that keeps the bus too long, but never in the middle of a byte.
// A guard gap with both chip selects high separates consecutive owners.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   req1/req2                        bus requests (held for whole transaction)
//   gnt1/gnt2, cs_n1/cs_n2           registered grants and chip selects
//   start*/tx_valid*/tx_data*        requester-side SPI controls
//   tx_ready*/rx_valid*/busy*        per-requester copies of master status
//   rx_data                          master RX byte, broadcast to both sides
//   m_*                              spi_master side
//   owner                            0 none, 1 sensor 1, 2 sensor 2
//   timeout_err                      one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module bno085_spi_arbiter #(
  parameter int GAP_CYCLES      = 3,
  parameter int MAX_HOLD_CYCLES = 30000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req1,
  input  logic       req2,
  output logic       gnt1,
  output logic       gnt2,
  output logic       cs_n1,
  output logic       cs_n2,
  input  logic       start1,
  input  logic       start2,
  input  logic       tx_valid1,
  input  logic       tx_valid2,
  input  logic [7:0] tx_data1,
  input  logic [7:0] tx_data2,
  output logic       tx_ready1,
  output logic       tx_ready2,
  output logic       rx_valid1,
  output logic       rx_valid2,
  output logic       busy1,
  output logic       busy2,
  output logic [7:0] rx_data,
  output logic       m_start,
  output logic       m_tx_valid,
  output logic [7:0] m_tx_data,
  input  logic       m_tx_ready,
  input  logic       m_rx_valid,
  input  logic       m_busy,
  input  logic [7:0] m_rx_data,
  output logic [1:0] owner,
  output logic       timeout_err
);

  // The hold counter only has to reach MAX_HOLD_CYCLES-1, the gap counter
  // GAP_CYCLES-1; both are kept at least one bit wide for degenerate values.
  localparam int HOLD_W = (MAX_HOLD_CYCLES > 1) ? $clog2(MAX_HOLD_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, OWN1, OWN2, GAP} state_t;

  state_t            state_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic [1:0]        last_served_reg;

  logic cur_req;
  logic at_limit;

  // Request of whichever sensor currently owns the bus.
  assign cur_req  = (state_reg == OWN1) ? req1 : req2;
  assign at_limit = (hold_cnt_reg == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      hold_cnt_reg    <= '0;
      gap_cnt_reg     <= '0;
      last_served_reg <= 2'd2;   // sensor 1 wins the first tie
      gnt1            <= 1'b0;
      gnt2            <= 1'b0;
      cs_n1           <= 1'b1;
      cs_n2           <= 1'b1;
      owner           <= 2'd0;
      timeout_err     <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          hold_cnt_reg <= '0;
          if (req1 && (!req2 || last_served_reg == 2'd2)) begin
            state_reg <= OWN1;
            gnt1      <= 1'b1;
            cs_n1     <= 1'b0;
            owner     <= 2'd1;
          end else if (req2) begin
            state_reg <= OWN2;
            gnt2      <= 1'b1;
            cs_n2     <= 1'b0;
            owner     <= 2'd2;
          end
        end

        OWN1, OWN2: begin
          // Release only between bytes. A still-asserted request means the
          // watchdog forced this release.
          if (!m_busy && (!cur_req || at_limit)) begin
            gnt1            <= 1'b0;
            gnt2            <= 1'b0;
            cs_n1           <= 1'b1;
            cs_n2           <= 1'b1;
            owner           <= 2'd0;
            timeout_err     <= cur_req;
            last_served_reg <= (state_reg == OWN1) ? 2'd1 : 2'd2;
            gap_cnt_reg     <= '0;
            state_reg       <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else if (!at_limit) begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
          end
        end

        GAP: begin
          // Pending requests are simply left asserted and picked up in IDLE.
          if (gap_cnt_reg == GAP_LAST) begin
            state_reg <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // Datapath steering keyed off the registered owner so it never glitches
  // between owners inside a cycle.
  always_comb begin
    m_start    = 1'b0;
    m_tx_valid = 1'b0;
    m_tx_data  = 8'h00;
    tx_ready1  = 1'b0;
    rx_valid1  = 1'b0;
    busy1      = 1'b0;
    tx_ready2  = 1'b0;
    rx_valid2  = 1'b0;
    busy2      = 1'b0;
    case (owner)
      2'd1: begin
        m_start    = start1;
        m_tx_valid = tx_valid1;
        m_tx_data  = tx_data1;
        tx_ready1  = m_tx_ready;
        rx_valid1  = m_rx_valid;
        busy1      = m_busy;
      end
      2'd2: begin
        m_start    = start2;
        m_tx_valid = tx_valid2;
        m_tx_data  = tx_data2;
        tx_ready2  = m_tx_ready;
        rx_valid2  = m_rx_valid;
        busy2      = m_busy;
      end
      default: ;
    endcase
  end

  assign rx_data = m_rx_data;

endmodule
